grf_sb: RTL and testbench
=========================

Name: grf_sb

Overview:
Parametrised general register file for the D stage, generalising the current single-pair GRF.
- NUM_RD combinational read ports and one write port fed from W.
- Optional W→D write-through bypass.
- Per-register pending-write scoreboard. It counts in-flight writers issued from D and raises a stall when a used source register is still pending.
- Replaces the ad-hoc stall logic and the GRF read path in one block.

Parameters:
DW, 32, data width of each register
NREG, 32, number of registers (power of 2, ≥2); register 0 hardwired to zero
AW, 5, address width = log2(NREG)
NUM_RD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
MAX_INFL, 3, max in-flight writes per register; counter width CW = clog2(MAX_INFL+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
rd_addr  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
rd_use  in  NUM_RD  port i source is actually consumed by the D instruction
rd_data  out  NUM_RD*DW  read data, port i at [i*DW +: DW]
wr_en  in  1  W-stage register write
wr_addr  in  AW  write destination
wr_data  in  DW  write data
issue_en  in  1  D instruction leaves D this cycle and will write a register
issue_addr  in  AW  destination of issued instruction
stall  out  1  at least one used source is pending
pend_cnt0  out  CW  pending count of rd_addr port 0 (debug/verification)
err  out  1  sticky: scoreboard overflow or underflow seen

Behaviour:
- Reset (reset=0, async):
  - All registers, all counters and err cleared to 0.
  - Outputs while held in reset: rd_data = 0 for every address, stall = 0.
- Write (posedge clk, reset=1):
  - If wr_en and wr_addr≠0, reg[wr_addr] ← wr_data.
  - Writes to register 0 are discarded; reg[0] always reads 0.
- Read (combinational, no latency): rd_data[i] = reg[rd_addr[i]].
  - If BYPASS=1, wr_en and wr_addr==rd_addr[i]≠0, rd_data[i] = wr_data instead.
  - rd_addr[i]==0 → 0 regardless of bypass.
  - All ports are independent; identical addresses on several ports are legal.
- Scoreboard counter cnt[r] per register r≠0; cnt[0] is constant 0. Per clock edge:
  - inc = issue_en && issue_addr==r && r≠0.
  - dec = wr_en && wr_addr==r && r≠0.
  - inc&&dec → unchanged (simultaneous issue and retire of the same register).
  - inc only:
    - cnt<MAX_INFL → cnt+1.
    - cnt==MAX_INFL → saturate and set err.
  - dec only:
    - cnt>0 → cnt−1.
    - cnt==0 → stays 0 and sets err; the data write still occurs.
  - err clears only on reset.
- Hazard for port i: rd_use[i] && cnt[rd_addr[i]]≠0.
  - Exception: BYPASS=1 && dec for that register this cycle && cnt==1. In that case the value is forwarded and there is no hazard.
- stall = OR of port hazards. Combinational, same cycle as the address.
- Upstream must hold issue_en=0 while stall=1. The block does not gate issue_en itself.
- pend_cnt0 = cnt[rd_addr[0 port]]; this is the pre-edge value.
- Timing: no output depends combinationally on issue_en or issue_addr. This avoids loops through stall.

Test Plan:
1. Reset then basic write/read:
   - Release reset; write reg5 ← 32'hDEAD_BEEF.
   - Next cycle rd_addr0=5 → rd_data0=DEADBEEF; rd_addr1=0 → 0.
   - Write reg0 ← 1 → reads 0.
2. Bypass, BYPASS=1:
   - Same cycle wr_en, wr_addr=7, wr_data=0x1234, rd_addr0=7 → rd_data0=0x1234 combinationally.
   - Repeat with BYPASS=0 → old value 0.
3. Scoreboard stall:
   - issue_en, issue_addr=3 → cnt3=1.
   - Next cycle rd_addr0=3, rd_use=01 → stall=1.
   - With rd_use=00 → stall=0.
   - wr_en to 3 with BYPASS=1 → stall=0 that cycle, cnt3=0 after the edge.
4. Multiple in-flight writers:
   - Issue reg9 three times → cnt=3.
   - A fourth issue → cnt stays 3 and err=1.
   - Two retires → cnt=1 and stall persists.
   - Third retire → cnt=0.
5. Simultaneous issue and retire of reg4 at cnt4=1 → cnt4 stays 1, data written, stall still 1 for a reader of reg4.
6. Async reset mid-operation:
   - With cnt2=2, err=1 and reg2=5, drop reset between clock edges.
   - Immediately: rd_data=0, stall=0.
   - After release: cnt2=0, err=0, reg2=0.
   - Retire to reg2 with cnt=0 → err=1 (underflow).

Source files
------------

// File: rtl/grf_sb.sv
// grf_sb: general register file for the D stage.
//   - NUM_RD combinational read ports.
//   - One write port fed from W, with optional W->D write-through.
//   - Per-register scoreboard of in-flight writers. It drives the D-stage stall.
module grf_sb #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int MAX_INFL = 3,
    localparam int CW      = $clog2(MAX_INFL + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic [NUM_RD-1:0]    rd_use,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    output logic                 stall,
    output logic [CW-1:0]        pend_cnt0,
    output logic                 err
);

    logic [DW-1:0] regs    [NREG];
    logic [CW-1:0] cnt     [NREG];
    logic [CW-1:0] cnt_nxt [NREG];
    logic          err_set;

    // Saturating counter step: an issue and a retire in the same cycle cancel out.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                               input logic inc, input logic dec);
        logic [CW-1:0] n;
        n = c;
        if (inc && !dec && c != CW'(MAX_INFL))
            n = c + CW'(1);
        else if (dec && !inc && c != '0)
            n = c - CW'(1);
        return n;
    endfunction

    // Overflow (issue at MAX_INFL) or underflow (retire at zero).
    function automatic logic cnt_fault(input logic [CW-1:0] c,
                                       input logic inc, input logic dec);
        return (inc && !dec && c == CW'(MAX_INFL)) || (dec && !inc && c == '0);
    endfunction

    // Register array. Register 0 is never written, so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Next-state computation for every scoreboard counter. Entry 0 is tied to zero.
    always_comb begin
        err_set    = 1'b0;
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_nxt[r] = cnt_next(cnt[r], issue_en && issue_addr == AW'(r),
                                  wr_en && wr_addr == AW'(r));
            err_set    = err_set | cnt_fault(cnt[r], issue_en && issue_addr == AW'(r),
                                             wr_en && wr_addr == AW'(r));
        end
    end

    // Scoreboard counters and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            err <= err | err_set;
        end
    end

    // Read ports and hazard detection.
    // A retire that drains the last in-flight writer is forwarded, so it is not a hazard.
    // Outputs are forced quiet while reset is held.
    always_comb begin
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        logic [CW-1:0] c;
        logic          fwd;
        logic          haz;
        rd_data = '0;
        haz     = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            a   = rd_addr[i*AW +: AW];
            c   = cnt[a];
            fwd = (BYPASS != 0) && wr_en && wr_addr == a && a != '0;
            v   = fwd ? wr_data : regs[a];
            if (a == '0 || !reset)
                v = '0;
            rd_data[i*DW +: DW] = v;
            if (rd_use[i] && c != '0 && !(fwd && c == CW'(1)))
                haz = 1'b1;
        end
        stall = haz && reset;
    end

    assign pend_cnt0 = cnt[rd_addr[AW-1:0]];

endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: scoreboard bench for grf_sb.
//   - Two instances: one with write-through enabled, one without.
//   - A behavioural model predicts each cycle's outputs; predictions are queued when
//     stimulus is driven and popped when the outputs are sampled.
module tb_grf_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_use;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;

    logic [63:0] rd_data, rd_data_nb;
    logic        stall, stall_nb;
    logic [1:0]  pend_cnt0, pend_cnt0_nb;
    logic        err, err_nb;

    always #5 clk = ~clk;

    grf_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .stall(stall), .pend_cnt0(pend_cnt0), .err(err)
    );

    grf_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .stall(stall_nb), .pend_cnt0(pend_cnt0_nb), .err(err_nb)
    );

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] rd0nb;
        logic        stl;
        logic [1:0]  pc0;
        logic        er;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    logic [31:0] m_reg[32];
    int          m_cnt[32];
    bit          m_err;

    logic [31:0] obs_rd0, obs_rd1, obs_rd0nb;
    logic        obs_stl, obs_err;
    logic [1:0]  obs_pc0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] model_rd(input int a, input bit byp);
        if (!reset || a == 0)
            return '0;
        if (byp && wr_en && wr_addr == a)
            return wr_data;
        return m_reg[a];
    endfunction

    function automatic exp_t model_predict();
        exp_t e;
        int   a;
        e.rd0   = model_rd(int'(rd_addr[4:0]), 1'b1);
        e.rd1   = model_rd(int'(rd_addr[9:5]), 1'b1);
        e.rd0nb = model_rd(int'(rd_addr[4:0]), 1'b0);
        e.stl   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? int'(rd_addr[4:0]) : int'(rd_addr[9:5]);
            if (reset && rd_use[i] && m_cnt[a] != 0 &&
                !(wr_en && wr_addr == a && a != 0 && m_cnt[a] == 1))
                e.stl = 1'b1;
        end
        e.pc0 = 2'(m_cnt[rd_addr[4:0]]);
        e.er  = m_err;
        return e;
    endfunction

    function automatic void model_clock();
        bit inc, dec;
        for (int r = 1; r < 32; r++) begin
            inc = issue_en && issue_addr == r;
            dec = wr_en && wr_addr == r;
            if (inc && !dec) begin
                if (m_cnt[r] < 3) m_cnt[r]++;
                else m_err = 1'b1;
            end else if (dec && !inc) begin
                if (m_cnt[r] > 0) m_cnt[r]--;
                else m_err = 1'b1;
            end
        end
        if (wr_en && wr_addr != 0)
            m_reg[wr_addr] = wr_data;
    endfunction

    // Pop the oldest prediction and compare it against the sampled outputs.
    task automatic sample_compare(input string tag);
        exp_t e;
        obs_rd0   = rd_data[31:0];
        obs_rd1   = rd_data[63:32];
        obs_rd0nb = rd_data_nb[31:0];
        obs_stl   = stall;
        obs_pc0   = pend_cnt0;
        obs_err   = err;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rd0"},   64'(obs_rd0),   64'(e.rd0));
            check({tag, "_rd1"},   64'(obs_rd1),   64'(e.rd1));
            check({tag, "_rd0nb"}, 64'(obs_rd0nb), 64'(e.rd0nb));
            check({tag, "_stall"}, 64'(obs_stl),   64'(e.stl));
            check({tag, "_pcnt"},  64'(obs_pc0),   64'(e.pc0));
            check({tag, "_err"},   64'(obs_err),   64'(e.er));
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, sample, then advance the model.
    task automatic cyc(input string tag, input bit we, input int wa, input logic [31:0] wd,
                       input bit ie, input int ia, input int ra0, input int ra1,
                       input bit [1:0] use_v);
        @(negedge clk);
        wr_en      = we;
        wr_addr    = 5'(wa);
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = 5'(ia);
        rd_addr    = {5'(ra1), 5'(ra0)};
        rd_use     = use_v;
        exp_q.push_back(model_predict());
        #1;
        sample_compare(tag);
        @(posedge clk);
        if (reset)
            model_clock();
    endtask

    task automatic idle_read(input string tag, input int ra0, input bit [1:0] use_v);
        cyc(tag, 1'b0, 0, 32'h0, 1'b0, 0, ra0, 0, use_v);
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        rd_addr = '0; rd_use = '0;
        model_reset();

        // Reset state: outputs quiet while reset is held.
        cyc("rst", 1'b1, 6, 32'h55, 1'b1, 6, 6, 0, 2'b01);
        check("rst_lit_rd0", 64'(obs_rd0), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic write and read.
        cyc("t1_wr", 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 2'b00);
        cyc("t1_rd", 1'b0, 0, 32'h0, 1'b0, 0, 5, 0, 2'b00);
        check("t1_lit_rd0", 64'(obs_rd0), 64'hDEAD_BEEF);
        check("t1_lit_rd1", 64'(obs_rd1), 64'd0);
        cyc("t1_w0", 1'b1, 0, 32'h1, 1'b0, 0, 0, 0, 2'b00);
        idle_read("t1_r0", 0, 2'b00);
        check("t1_lit_r0", 64'(obs_rd0), 64'd0);

        // Same-cycle write-through versus array-only reads.
        cyc("t2_byp", 1'b1, 7, 32'h1234, 1'b0, 0, 7, 0, 2'b00);
        check("t2_lit_byp", 64'(obs_rd0), 64'h1234);
        check("t2_lit_nobyp", 64'(obs_rd0nb), 64'h0);

        // Single pending writer.
        cyc("t3_iss", 1'b0, 0, 32'h0, 1'b1, 3, 0, 0, 2'b00);
        idle_read("t3_stl", 3, 2'b01);
        check("t3_lit_stall", 64'(obs_stl), 64'd1);
        idle_read("t3_nouse", 3, 2'b00);
        check("t3_lit_nouse", 64'(obs_stl), 64'd0);
        cyc("t3_ret", 1'b1, 3, 32'hAA, 1'b0, 0, 3, 0, 2'b01);
        check("t3_lit_ret", 64'(obs_stl), 64'd0);
        idle_read("t3_aft", 3, 2'b01);
        check("t3_lit_cnt", 64'(obs_pc0), 64'd0);

        // Several writers in flight, then saturation.
        for (int k = 0; k < 3; k++)
            cyc("t4_iss", 1'b0, 0, 32'h0, 1'b1, 9, 0, 0, 2'b00);
        idle_read("t4_full", 9, 2'b01);
        check("t4_lit_cnt3", 64'(obs_pc0), 64'd3);
        cyc("t4_ovf", 1'b0, 0, 32'h0, 1'b1, 9, 0, 0, 2'b00);
        idle_read("t4_sat", 9, 2'b01);
        check("t4_lit_sat", 64'(obs_pc0), 64'd3);
        check("t4_lit_err", 64'(obs_err), 64'd1);
        for (int k = 0; k < 2; k++)
            cyc("t4_ret", 1'b1, 9, 32'(k + 16), 1'b0, 0, 0, 0, 2'b00);
        idle_read("t4_one", 9, 2'b01);
        check("t4_lit_cnt1", 64'(obs_pc0), 64'd1);
        check("t4_lit_stl", 64'(obs_stl), 64'd1);
        cyc("t4_last", 1'b1, 9, 32'h99, 1'b0, 0, 9, 0, 2'b01);
        idle_read("t4_zero", 9, 2'b01);
        check("t4_lit_cnt0", 64'(obs_pc0), 64'd0);

        // Issue and retire of the same register in one cycle.
        cyc("t5_iss", 1'b0, 0, 32'h0, 1'b1, 4, 0, 0, 2'b00);
        cyc("t5_both", 1'b1, 4, 32'h44, 1'b1, 4, 0, 0, 2'b00);
        idle_read("t5_aft", 4, 2'b01);
        check("t5_lit_cnt", 64'(obs_pc0), 64'd1);
        check("t5_lit_data", 64'(obs_rd0), 64'h44);
        check("t5_lit_stl", 64'(obs_stl), 64'd1);

        // Asynchronous reset between clock edges.
        cyc("t6_wr", 1'b1, 2, 32'h5, 1'b0, 0, 0, 0, 2'b00);
        cyc("t6_i1", 1'b0, 0, 32'h0, 1'b1, 2, 0, 0, 2'b00);
        cyc("t6_i2", 1'b0, 0, 32'h0, 1'b1, 2, 0, 0, 2'b00);
        @(negedge clk);
        wr_en = 1'b0; issue_en = 1'b0; rd_addr = {5'd2, 5'd2}; rd_use = 2'b11;
        #2;
        reset = 1'b0;
        model_reset();
        exp_q.push_back(model_predict());
        #1;
        sample_compare("t6_inrst");
        check("t6_lit_stall", 64'(obs_stl), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_read("t6_post", 2, 2'b01);
        check("t6_lit_err", 64'(obs_err), 64'd0);
        cyc("t6_unf", 1'b1, 2, 32'h7, 1'b0, 0, 0, 0, 2'b00);
        idle_read("t6_unf_chk", 2, 2'b00);
        check("t6_lit_unf", 64'(obs_err), 64'd1);

        // Randomised traffic over a small register window.
        for (int k = 0; k < 60; k++)
            cyc("rnd", 1'($urandom), int'($urandom_range(0, 7)), $urandom,
                1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), 2'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
